selection_cursor_ctrl: RTL and testbench

Generates the h_offset/v_offset position of the red 100x100 selection square drawn over the 400x400 image by the downstream image drawer. Synchronizes and debounces five raw push-buttons and keeps the square on a tile grid. Commits moves only at frame start so the square never tears mid-frame. Reports the selected tile index on confirm, for the CPU/memory side.

---
 rtl/selection_cursor_ctrl.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_selection_cursor_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/selection_cursor_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : selection_cursor_ctrl
// Description : Position controller for the 100x100 selection square drawn
//               over the 400x400 image. Five raw push-buttons are
//               synchronised and debounced. Their rising edges queue a
//               pending move, and the move is committed only at frame start
//               so the square never tears mid-frame. A confirm press reports
//               the committed tile index.
// Revision    : 1.0 - initial release
//
// Ports:
//   clk           system (pixel) clock
//   rst           asynchronous active-high reset
//   btn_up/down/left/right/confirm
//                 raw asynchronous buttons, active-high
//   frame_start   one-cycle pulse at the first cycle of vertical blanking
//   h_offset      square left edge in pixels (col*STEP)
//   v_offset      square top edge in pixels  (row*STEP)
//   sel_index     committed tile index (row*(MAX_COL+1)+col)
//   sel_valid     one-cycle pulse qualifying sel_index after a confirm
//   move_pending  high while a move waits for frame_start
//
// Build option:
//   CURSOR_WRAP_EN  when defined, moves past an edge wrap to the opposite
//                   edge. Otherwise they saturate at the edge.
// ============================================================================
module selection_cursor_ctrl #(
    parameter int STEP            = 100,
    parameter int GRID_W          = 400,
    parameter int GRID_H          = 400,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_confirm,
    input  logic       frame_start,
    output logic [8:0] h_offset,
    output logic [8:0] v_offset,
    output logic [3:0] sel_index,
    output logic       sel_valid,
    output logic       move_pending
);

    localparam int c_MAX_COL = GRID_W / STEP - 1;
    localparam int c_MAX_ROW = GRID_H / STEP - 1;
    localparam int c_CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [8:0]         c_STEP     = 9'(STEP);
    localparam logic [8:0]         c_H_LAST   = 9'(c_MAX_COL * STEP);
    localparam logic [8:0]         c_V_LAST   = 9'(c_MAX_ROW * STEP);
    localparam logic [3:0]         c_COL_LAST = 4'(c_MAX_COL);
    localparam logic [3:0]         c_ROW_LAST = 4'(c_MAX_ROW);
    localparam logic [3:0]         c_COLS     = 4'(c_MAX_COL + 1);

    // Button slots in the raw/press vectors
    localparam int c_BTN_UP      = 0;
    localparam int c_BTN_DOWN    = 1;
    localparam int c_BTN_LEFT    = 2;
    localparam int c_BTN_RIGHT   = 3;
    localparam int c_BTN_CONFIRM = 4;

    // Pending direction encoding: none / +1 / -1
    localparam logic [1:0] c_DIR_NONE  = 2'b00;
    localparam logic [1:0] c_DIR_PLUS  = 2'b01;
    localparam logic [1:0] c_DIR_MINUS = 2'b11;

    localparam logic [0:0] c_ST_IDLE    = 1'b0;
    localparam logic [0:0] c_ST_PENDING = 1'b1;

    logic [4:0] w_btn_raw;
    logic [4:0] w_press;

    assign w_btn_raw = {btn_confirm, btn_right, btn_left, btn_down, btn_up};

    // ------------------------------------------------------------------------
    // Per-button synchroniser, debouncer and rising-edge detector
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_btn
            logic               r_sync1;
            logic               r_sync2;
            logic               r_level;
            logic               r_level_d;
            logic [c_CNT_W-1:0] r_cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync1   <= 1'b0;
                    r_sync2   <= 1'b0;
                    r_level   <= 1'b0;
                    r_level_d <= 1'b0;
                    r_cnt     <= '0;
                end else begin
                    r_sync1   <= w_btn_raw[gi];
                    r_sync2   <= r_sync1;
                    r_level_d <= r_level;
                    // Any cycle that agrees with the accepted level restarts
                    // the stability count, so a glitch never accumulates.
                    if (r_sync2 == r_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_level <= ~r_level;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
            end

            // Press only; releases are ignored.
            assign w_press[gi] = r_level & ~r_level_d;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Move FSM and pending direction registers
    // ------------------------------------------------------------------------
    logic [0:0] r_state;
    logic [0:0] w_state_next;
    logic [1:0] r_dh;
    logic [1:0] r_dv;
    logic [1:0] w_dh_next;
    logic [1:0] w_dv_next;
    logic       w_apply;
    logic       w_move_press;

    assign w_apply      = (r_state == c_ST_PENDING) && frame_start;
    assign w_move_press = |w_press[c_BTN_RIGHT:c_BTN_UP];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_dh    <= c_DIR_NONE;
            r_dv    <= c_DIR_NONE;
        end else begin
            r_state <= w_state_next;
            r_dh    <= w_dh_next;
            r_dv    <= w_dv_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        // An applied move is consumed; a press arriving on the same cycle
        // becomes the next pending move instead of joining this one.
        w_dh_next    = w_apply ? c_DIR_NONE : r_dh;
        w_dv_next    = w_apply ? c_DIR_NONE : r_dv;

        // Opposing presses on one axis cancel and leave that axis untouched.
        if (w_press[c_BTN_LEFT] && !w_press[c_BTN_RIGHT]) begin
            w_dh_next = c_DIR_MINUS;
        end else if (w_press[c_BTN_RIGHT] && !w_press[c_BTN_LEFT]) begin
            w_dh_next = c_DIR_PLUS;
        end

        if (w_press[c_BTN_UP] && !w_press[c_BTN_DOWN]) begin
            w_dv_next = c_DIR_MINUS;
        end else if (w_press[c_BTN_DOWN] && !w_press[c_BTN_UP]) begin
            w_dv_next = c_DIR_PLUS;
        end

        case (r_state)
            c_ST_IDLE: begin
                if (w_move_press) begin
                    w_state_next = c_ST_PENDING;
                end
            end
            c_ST_PENDING: begin
                if (w_apply) begin
                    w_state_next = w_move_press ? c_ST_PENDING : c_ST_IDLE;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Position datapath: bounds are checked on col/row first, so the 9-bit
    // offsets only ever step by +/-STEP inside the image.
    // ------------------------------------------------------------------------
    logic [3:0] r_col;
    logic [3:0] r_row;
    logic [8:0] r_h;
    logic [8:0] r_v;
    logic [3:0] r_sel_index;
    logic [3:0] w_col_next;
    logic [3:0] w_row_next;
    logic [8:0] w_h_next;
    logic [8:0] w_v_next;
    logic [3:0] w_sel_next;

    always_comb begin
        w_col_next = r_col;
        w_row_next = r_row;
        w_h_next   = r_h;
        w_v_next   = r_v;

        if (r_dh == c_DIR_PLUS) begin
            if (r_col != c_COL_LAST) begin
                w_col_next = r_col + 4'd1;
                w_h_next   = r_h + c_STEP;
            end
`ifdef CURSOR_WRAP_EN
            else begin
                w_col_next = 4'd0;
                w_h_next   = 9'd0;
            end
`endif
        end else if (r_dh == c_DIR_MINUS) begin
            if (r_col != 4'd0) begin
                w_col_next = r_col - 4'd1;
                w_h_next   = r_h - c_STEP;
            end
`ifdef CURSOR_WRAP_EN
            else begin
                w_col_next = c_COL_LAST;
                w_h_next   = c_H_LAST;
            end
`endif
        end

        if (r_dv == c_DIR_PLUS) begin
            if (r_row != c_ROW_LAST) begin
                w_row_next = r_row + 4'd1;
                w_v_next   = r_v + c_STEP;
            end
`ifdef CURSOR_WRAP_EN
            else begin
                w_row_next = 4'd0;
                w_v_next   = 9'd0;
            end
`endif
        end else if (r_dv == c_DIR_MINUS) begin
            if (r_row != 4'd0) begin
                w_row_next = r_row - 4'd1;
                w_v_next   = r_v - c_STEP;
            end
`ifdef CURSOR_WRAP_EN
            else begin
                w_row_next = c_ROW_LAST;
                w_v_next   = c_V_LAST;
            end
`endif
        end

        w_sel_next = w_row_next * c_COLS + w_col_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col       <= 4'd0;
            r_row       <= 4'd0;
            r_h         <= 9'd0;
            r_v         <= 9'd0;
            r_sel_index <= 4'd0;
        end else if (w_apply) begin
            r_col       <= w_col_next;
            r_row       <= w_row_next;
            r_h         <= w_h_next;
            r_v         <= w_v_next;
            r_sel_index <= w_sel_next;
        end
    end

    // ------------------------------------------------------------------------
    // Confirm reporting. A confirm landing on an applying frame_start is held
    // back one cycle so it reports the index after the move.
    // ------------------------------------------------------------------------
    logic r_sel_valid;
    logic r_confirm_defer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel_valid     <= 1'b0;
            r_confirm_defer <= 1'b0;
        end else begin
            r_sel_valid     <= (w_press[c_BTN_CONFIRM] && !w_apply) || r_confirm_defer;
            r_confirm_defer <= w_press[c_BTN_CONFIRM] && w_apply;
        end
    end

    assign h_offset     = r_h;
    assign v_offset     = r_v;
    assign sel_index    = r_sel_index;
    assign sel_valid    = r_sel_valid;
    assign move_pending = (r_state == c_ST_PENDING);

endmodule
`default_nettype wire

// File: tb/tb_selection_cursor_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_selection_cursor_ctrl
// Description : Self-checking bench for selection_cursor_ctrl with a short
//               debounce window. Expected confirm reports and position
//               changes are queued by the stimulus and consumed by a monitor
//               whenever the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_selection_cursor_ctrl;

    localparam int c_DEB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] btn;          // 0 up, 1 down, 2 left, 3 right, 4 confirm
    logic       frame_start;
    logic [8:0] h_offset;
    logic [8:0] v_offset;
    logic [3:0] sel_index;
    logic       sel_valid;
    logic       move_pending;

    int tests_run = 0;
    int tests_failed = 0;

    logic [3:0]  sel_q[$];
    logic [21:0] pos_q[$];
    logic [21:0] prev_pos;

    selection_cursor_ctrl #(
        .STEP(100), .GRID_W(400), .GRID_H(400), .DEBOUNCE_CYCLES(c_DEB)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_up(btn[0]), .btn_down(btn[1]), .btn_left(btn[2]),
        .btn_right(btn[3]), .btn_confirm(btn[4]),
        .frame_start(frame_start),
        .h_offset(h_offset), .v_offset(v_offset), .sel_index(sel_index),
        .sel_valid(sel_valid), .move_pending(move_pending)
    );

    always #5 clk = ~clk;

    // Monitor: consumes expected confirm reports and position changes.
    always @(negedge clk) begin
        logic [21:0] cur;
        logic [21:0] exp_pos;
        logic [3:0]  exp_sel;
        cur = {h_offset, v_offset, sel_index};
        if (rst) begin
            prev_pos = cur;
        end else begin
            if (sel_valid) begin
                tests_run++;
                if (sel_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sel_valid_unexpected: got sel_index=%0d, required no report", sel_index);
                end else begin
                    exp_sel = sel_q.pop_front();
                    if (sel_index !== exp_sel) begin
                        tests_failed++;
                        $display("FAIL sel_report: got sel_index=%0d, required %0d", sel_index, exp_sel);
                    end
                end
            end
            if (cur !== prev_pos) begin
                tests_run++;
                if (pos_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL pos_unexpected: got h=%0d v=%0d idx=%0d, required no change",
                             h_offset, v_offset, sel_index);
                end else begin
                    exp_pos = pos_q.pop_front();
                    if (cur !== exp_pos) begin
                        tests_failed++;
                        $display("FAIL pos_change: got h=%0d v=%0d idx=%0d, required h=%0d v=%0d idx=%0d",
                                 h_offset, v_offset, sel_index,
                                 exp_pos[21:13], exp_pos[12:4], exp_pos[3:0]);
                    end
                end
            end
            prev_pos = cur;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn = 5'b0;
        frame_start = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic press(input logic [4:0] mask);
        btn = btn | mask;
        tick(12);
        btn = btn & ~mask;
        tick(10);
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        tick(1);
    endtask

    task automatic push_pos(input int h, input int v, input int idx);
        pos_q.push_back({9'(h), 9'(v), 4'(idx)});
    endtask

    initial begin
        rst = 1'b1;
        btn = 5'b0;
        frame_start = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(2);

        // Reset state
        check("reset_h_offset", h_offset, 0);
        check("reset_v_offset", v_offset, 0);
        check("reset_sel_index", sel_index, 0);
        check("reset_sel_valid", sel_valid, 0);
        check("reset_move_pending", move_pending, 0);

        // Press latency: pending rises 7 cycles after the raw edge
        btn[3] = 1'b1;
        tick(6);
        check("latency_pending_early", move_pending, 0);
        tick(1);
        check("latency_pending_on_time", move_pending, 1);
        tick(13);
        btn[3] = 1'b0;
        tick(10);
        check("h_stable_while_pending", h_offset, 0);
        push_pos(100, 0, 1);
        frame();
        check("pending_cleared_after_frame", move_pending, 0);

        // Bouncing press counts once
        do_reset();
        btn[3] = 1'b1;
        tick(1);
        btn[3] = 1'b0;
        tick(2);
        btn[3] = 1'b1;
        tick(12);
        btn[3] = 1'b0;
        tick(10);
        check("bounce_pending", move_pending, 1);
        push_pos(100, 0, 1);
        frame();
        check("bounce_single_step", h_offset, 100);
        frame();
        check("idle_frame_no_move", h_offset, 100);

        // Right edge: saturate (default) or wrap
        press(5'b01000); push_pos(200, 0, 2); frame();
        press(5'b01000); push_pos(300, 0, 3); frame();
        press(5'b01000);
        check("edge_pending", move_pending, 1);
`ifdef CURSOR_WRAP_EN
        push_pos(0, 0, 0);
        frame();
        check("edge_h_offset", h_offset, 0);
        check("edge_sel_index", sel_index, 0);
`else
        frame();
        check("edge_h_offset", h_offset, 300);
        check("edge_sel_index", sel_index, 3);
`endif
        check("edge_pending_consumed", move_pending, 0);

        // Down overwritten by up; at row 0 the up clamps (or wraps)
        do_reset();
        press(5'b00010);
        press(5'b00001);
        check("overwrite_pending", move_pending, 1);
`ifdef CURSOR_WRAP_EN
        push_pos(0, 300, 12);
        frame();
        check("overwrite_v_offset", v_offset, 300);
`else
        frame();
        check("overwrite_v_offset", v_offset, 0);
`endif
        check("overwrite_pending_cleared", move_pending, 0);

        // Simultaneous left+right leaves the pending left in place
        do_reset();
        press(5'b01000); push_pos(100, 0, 1); frame();
        press(5'b00100);
        press(5'b01100);
        push_pos(0, 0, 0);
        frame();
        check("opposing_keeps_dh", h_offset, 0);

        // Confirm at row 2, col 1
        do_reset();
        press(5'b00010); push_pos(0, 100, 4); frame();
        press(5'b00010); push_pos(0, 200, 8); frame();
        press(5'b01000); push_pos(100, 200, 9); frame();
        sel_q.push_back(4'd9);
        btn[4] = 1'b1;
        tick(6);
        check("confirm_not_early", sel_valid, 0);
        tick(1);
        check("confirm_on_time", sel_valid, 1);
        check("confirm_index", sel_index, 9);
        tick(5);
        btn[4] = 1'b0;
        tick(10);

        // Confirm coinciding with an applying frame_start
        press(5'b01000);
        sel_q.push_back(4'd10);
        push_pos(200, 200, 10);
        btn[4] = 1'b1;
        tick(6);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        check("coincide_not_normal_cycle", sel_valid, 0);
        check("coincide_index_updated", sel_index, 10);
        tick(1);
        check("coincide_deferred_valid", sel_valid, 1);
        tick(4);
        btn[4] = 1'b0;
        tick(10);

        // Confirm does not clear a pending move
        press(5'b00100);
        sel_q.push_back(4'd10);
        press(5'b10000);
        check("confirm_keeps_pending", move_pending, 1);
        push_pos(100, 200, 9);
        frame();
        check("confirm_then_move_cleared", move_pending, 0);

        // Reset while pending discards the move
        do_reset();
        press(5'b01000);
        check("rst_pending_before", move_pending, 1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        check("rst_pending_cleared", move_pending, 0);
        frame();
        check("rst_no_move_h", h_offset, 0);
        check("rst_no_move_pending", move_pending, 0);

        // Reset mid-debounce discards the partial count
        btn[3] = 1'b1;
        tick(4);
        rst = 1'b1;
        btn[3] = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(10);
        check("rst_debounce_no_pending", move_pending, 0);
        frame();
        check("rst_debounce_no_move", h_offset, 0);

        tick(5);
        check("sel_queue_drained", sel_q.size(), 0);
        check("pos_queue_drained", pos_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
